// File: rtl/stream_row_gather_if.sv
// AXI-stream style channel shared by the row gather stage and its neighbours.
// Sideband widths are parameters so producers and consumers agree on one definition.
interface nasti_stream_channel #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 4
) ();
  logic                  t_valid;
  logic                  t_ready;
  logic [DATA_W-1:0]     t_data;
  logic [DATA_W/8-1:0]   t_keep;
  logic [DATA_W/8-1:0]   t_strb;
  logic                  t_last;
  logic [ID_W-1:0]       t_id;
  logic [DEST_W-1:0]     t_dest;
  logic [USER_W-1:0]     t_user;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/stream_row_gather.sv
// Collects eight 8-coefficient rows into one 8x8 block beat for the transpose stage.
// Short blocks (t_last before the 8th row) are discarded and counted.
module stream_row_gather #(
  parameter int COEF_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  nasti_stream_channel.slave   in_ch,
  nasti_stream_channel.master  out_ch,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 busy
);

  localparam int ROW_W = 8 * COEF_WIDTH;
  localparam int BLK_W = 64 * COEF_WIDTH;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]            row_cnt;
  logic [ROW_W-1:0]      row_in;
  logic [ROW_W-1:0]      row_buf_p0 [0:6];
  logic [BLK_W-1:0]      blk_nxt;
  logic [BLK_W-1:0]      blk_p1;
  logic                  vld_p1;
  logic                  last_p1;
  logic [ID_WIDTH-1:0]   id_p0,   id_p1;
  logic [DEST_WIDTH-1:0] dest_p0, dest_p1;
  logic [USER_WIDTH-1:0] user_p0, user_p1;
  logic                  hs_in;
  logic                  hs_out;
  logic                  load;
  logic                  store;
  logic                  drop;
  logic                  unused_in_sideband;

  assign row_in = in_ch.t_data[ROW_W-1:0];
  assign unused_in_sideband = ^{in_ch.t_keep, in_ch.t_strb};

  // Only the 8th row can be stalled: it needs the output register to be free or draining.
  assign in_ch.t_ready = !((row_cnt == 3'd7) && vld_p1 && !out_ch.t_ready);
  assign hs_in  = in_ch.t_valid && in_ch.t_ready;
  assign hs_out = vld_p1 && out_ch.t_ready;
  assign load   = hs_in && (row_cnt == 3'd7);
  assign store  = hs_in && (row_cnt != 3'd7) && !in_ch.t_last;
  assign drop   = hs_in && (row_cnt != 3'd7) && in_ch.t_last;
  assign busy   = (row_cnt != 3'd0);

  always_comb begin
    blk_nxt = '0;
    for (int r = 0; r < 7; r++) begin
      blk_nxt[r*ROW_W +: ROW_W] = row_buf_p0[r];
    end
    blk_nxt[7*ROW_W +: ROW_W] = row_in;
  end

  // p0: row assembly buffer (data only, never read before written)
  always_ff @(posedge aclk) begin
    if (store) begin
      row_buf_p0[row_cnt] <= row_in;
    end
  end

  // p1: block output register data
  always_ff @(posedge aclk) begin
    if (load) begin
      blk_p1 <= blk_nxt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      row_cnt  <= 3'd0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      drop_cnt <= '0;
      id_p0    <= '0;
      dest_p0  <= '0;
      user_p0  <= '0;
      id_p1    <= '0;
      dest_p1  <= '0;
      user_p1  <= '0;
    end else begin
      if (hs_in && (row_cnt == 3'd0)) begin
        id_p0   <= in_ch.t_id;
        dest_p0 <= in_ch.t_dest;
        user_p0 <= in_ch.t_user;
      end
      if (load) begin
        row_cnt <= 3'd0;
        vld_p1  <= 1'b1;
        last_p1 <= in_ch.t_last;
        id_p1   <= id_p0;
        dest_p1 <= dest_p0;
        user_p1 <= user_p0;
      end else if (hs_out) begin
        vld_p1  <= 1'b0;
      end
      if (store) begin
        row_cnt <= row_cnt + 3'd1;
      end
      if (drop) begin
        row_cnt  <= 3'd0;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_comb begin
    out_ch.t_data = '0;
    out_ch.t_data[BLK_W-1:0] = blk_p1;
  end

  assign out_ch.t_valid = vld_p1;
  assign out_ch.t_last  = last_p1;
  assign out_ch.t_id    = id_p1;
  assign out_ch.t_dest  = dest_p1;
  assign out_ch.t_user  = user_p1;
  assign out_ch.t_keep  = '1;
  assign out_ch.t_strb  = '1;

endmodule

// File: doc/stream_row_gather.md
STREAM_ROW_GATHER -- requirements
Module: stream_row_gather

Interface
REQ-001 Parameter COEF_WIDTH SHALL exist: default 16, width of one signed coefficient.
REQ-002 Parameter CNT_WIDTH SHALL exist: default 16, width of the drop counter.
REQ-003 Port aclk SHALL be: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 Port areset SHALL be: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port in_ch SHALL be: nasti_stream_channel.slave, row beats; coefficient c at t_data[c*COEF_WIDTH +: COEF_WIDTH], c=0..7; t_data bits above 8*COEF_WIDTH ignored.
REQ-006 Port out_ch SHALL be: nasti_stream_channel.master, one 8x8 block per beat; element [r][c] at t_data[(r*8+c)*COEF_WIDTH +: COEF_WIDTH]; this is the block format consumed by the transpose stage.
REQ-007 Port drop_cnt SHALL be: output, CNT_WIDTH bits, count of discarded partial blocks.
REQ-008 Port busy SHALL be: output, 1 bit, high while a partial block is held (row_cnt != 0).

Function
REQ-009 Accepted rows SHALL be stored in an assembly buffer of 7 rows (rows 0..6), indexed by a 3-bit row_cnt.
REQ-010 An input handshake SHALL occur when in_ch.t_valid and in_ch.t_ready are both high.
REQ-011 in_ch.t_ready SHALL be low only when row_cnt==7 and out_ch.t_valid==1 and out_ch.t_ready==0; otherwise high.
REQ-012 On a handshake with row_cnt<7 and in_ch.t_last==0, the row SHALL be written to buffer[row_cnt] and row_cnt SHALL increment.
REQ-013 On a handshake with row_cnt==0, t_id, t_dest and t_user SHALL be captured as the block's sideband.
REQ-014 On a handshake with row_cnt==7, the output register SHALL load rows 0..6 from the buffer and row 7 from in_ch.t_data, and out_ch.t_valid SHALL be 1 on the next cycle.
REQ-015 In that same handshake, out_ch.t_last SHALL load in_ch.t_last, and row_cnt SHALL return to 0.
REQ-016 Latency SHALL be one cycle from the 8th-row handshake to out_ch.t_valid.
REQ-017 Throughput SHALL be one row per cycle; back-to-back blocks SHALL incur no bubble when out_ch.t_ready stays high.
REQ-018 out_ch.t_valid SHALL clear after an output handshake, unless the output register is reloaded in the same cycle.
REQ-019 While out_ch.t_valid==1 and out_ch.t_ready==0, t_data, t_last, t_id, t_dest and t_user SHALL remain stable.
REQ-020 A simultaneous output handshake and 8th-row handshake SHALL reload the output register; out_ch.t_valid SHALL stay 1.
REQ-021 out_ch.t_keep and out_ch.t_strb SHALL be all ones whenever out_ch.t_valid==1.
REQ-022 Short block: on a handshake with in_ch.t_last==1 and row_cnt<7, the beat and all buffered rows SHALL be discarded.
REQ-023 For that short block, row_cnt SHALL return to 0 and drop_cnt SHALL increment.
REQ-024 drop_cnt SHALL saturate at all ones.
REQ-025 The input t_keep and t_strb values SHALL be ignored.

Reset
REQ-026 While areset is high, row_cnt, out_ch.t_valid, out_ch.t_last, drop_cnt and busy SHALL be 0, and the captured sideband SHALL be 0.
REQ-027 While areset is high, in_ch.t_ready SHALL be 1.
REQ-028 Assertion of areset mid-block or mid-stall SHALL discard all buffered rows and any held output beat without producing an output handshake.
REQ-029 The first handshake after reset release SHALL be treated as row 0.
REQ-030 The assembly buffer data SHALL need no reset; it SHALL NOT be observable before it is written.

Verification
REQ-031 Scenario, single block: rows r=0..7 with coefficient c = r*8+c, t_last on row 7, out_ch.t_ready=1 -> one output beat one cycle after row 7; element [r][c]=r*8+c; t_last=1.
REQ-032 Scenario, backpressure: two blocks back-to-back, out_ch.t_ready=0 for 20 cycles -> first block held stable; in_ch.t_ready drops at row_cnt==7 of the second block; second block emitted after release; no rows lost.
REQ-033 Scenario, streaming: 4 blocks, continuous t_valid, out_ch.t_ready=1 -> 32 input handshakes in 32 cycles; output beats on cycles 8, 16, 24, 32 after the first row.
REQ-034 Scenario, short block: 3 rows with t_last on the 3rd, then a full block -> drop_cnt=1; exactly one output beat, equal to the full block.
REQ-035 Scenario, reset mid-block: areset pulsed after 5 rows, then 8 rows -> one output beat containing only the post-reset rows; drop_cnt=0.
REQ-036 Scenario, sideband: row 0 with t_id=3, t_user=5, rows 1..7 with other values -> output beat carries t_id=3, t_user=5; t_keep and t_strb all ones.
